// File: rtl/image_filter_3x3_stream.sv
// Streaming 3x3 neighbourhood filter (average / Gaussian / sharpen / bypass) over a raster pixel stream.
// Define FILTER_ROUND_EN to round average and Gaussian results to nearest instead of truncating.
module image_filter_3x3_stream #(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);
  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(N + IMG_W + 1);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int ACC_W = PIX_W + 4;
  localparam logic [ACC_W-1:0]        NINE = ACC_W'(9);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << PIX_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN} state_t;

  state_t           r_state;
  logic             r_in_ready, r_busy, r_done, r_out_valid;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [COL_W-1:0] r_col, r_ocol;
  logic [ROW_W-1:0] r_orow;
  logic             r_s1_valid, r_s1_border, r_s1_last;
  logic [PIX_W-1:0] r_out_pixel;
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_lb2 [IMG_W];
  logic [PIX_W-1:0] r_win [3][3];

  // Handshake: a pixel transfers on every rising edge where in_valid and in_ready are both 1;
  // the output side has no backpressure and out_valid marks each produced pixel.
  logic w_accept, w_drain, w_emit;
  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = (r_state == S_DRAIN);
  assign w_emit   = (r_state == S_RUN && w_accept) || w_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_mode      <= 2'd0;
      r_cnt       <= '0;
      r_col       <= '0;
      r_ocol      <= '0;
      r_orow      <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_last   <= 1'b0;
    end else begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      case (r_state)
        S_IDLE: if (start && !r_busy) begin
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b1;
          r_mode     <= mode;
          r_cnt      <= '0;
          r_col      <= '0;
          r_ocol     <= '0;
          r_orow     <= '0;
        end
        S_FILL, S_RUN: if (w_accept) begin
          r_cnt <= r_cnt + 1'b1;
          r_col <= (r_col == COL_W'(IMG_W - 1)) ? '0 : r_col + 1'b1;
          if (r_state == S_FILL && r_cnt == CNT_W'(IMG_W)) r_state <= S_RUN;
          if (r_state == S_RUN && r_cnt == CNT_W'(N - 1)) begin
            r_state    <= S_DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt + 1'b1;
          r_col <= (r_col == COL_W'(IMG_W - 1)) ? '0 : r_col + 1'b1;
          if (r_cnt == CNT_W'(N + IMG_W)) begin
            r_state   <= S_IDLE;
            r_s1_last <= 1'b1;
          end
        end
      endcase
      // Output-position counters track the centre pixel of the window being emitted.
      if (w_emit) begin
        r_s1_valid  <= 1'b1;
        r_s1_border <= (r_orow == '0) || (r_orow == ROW_W'(IMG_H - 1)) ||
                       (r_ocol == '0) || (r_ocol == COL_W'(IMG_W - 1));
        if (r_ocol == COL_W'(IMG_W - 1)) begin
          r_ocol <= '0;
          r_orow <= (r_orow == ROW_W'(IMG_H - 1)) ? '0 : r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end
    end
  end

  // Window rows: 0 = two rows up, 1 = previous row, 2 = incoming row; column 2 is newest.
  always_ff @(posedge clk) begin
    if (w_accept || w_drain) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= r_lb2[r_col];
      r_win[1][2] <= r_lb1[r_col];
      r_win[2][2] <= in_pixel;
    end
    if (w_accept) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_pixel;
    end
  end

  logic [ACC_W-1:0]        w_c, w_nsew, w_diag, w_s9, w_g, w_avg, w_gau;
  logic signed [ACC_W-1:0] w_res;
  logic [PIX_W-1:0]        w_pix;

  always_comb begin
    w_c    = {4'b0, r_win[1][1]};
    w_nsew = {4'b0, r_win[0][1]} + {4'b0, r_win[2][1]} + {4'b0, r_win[1][0]} + {4'b0, r_win[1][2]};
    w_diag = {4'b0, r_win[0][0]} + {4'b0, r_win[0][2]} + {4'b0, r_win[2][0]} + {4'b0, r_win[2][2]};
    w_s9   = w_c + w_nsew + w_diag;
    w_g    = (w_c << 2) + (w_nsew << 1) + w_diag;
`ifdef FILTER_ROUND_EN
    w_avg  = (w_s9 + ACC_W'(4)) / NINE;
    w_gau  = (w_g + ACC_W'(8)) >> 4;
`else
    w_avg  = w_s9 / NINE;
    w_gau  = w_g >> 4;
`endif
    case (r_mode)
      2'd0:    w_res = $signed(w_avg);
      2'd1:    w_res = $signed(w_gau);
      2'd2:    w_res = $signed((w_c << 2) + w_c) - $signed(w_nsew);
      default: w_res = $signed(w_c);
    endcase
    if (r_s1_border) w_res = $signed(w_c);
    if (w_res[ACC_W-1])   w_pix = '0;
    else if (w_res > MAXV) w_pix = '1;
    else                   w_pix = w_res[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_done      <= r_s1_last;
      if (r_s1_valid) r_out_pixel <= w_pix;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_pixel = r_out_pixel;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;
endmodule
